// File: rtl/bp_be_fe_queue_buffer_pkg.sv
// Shared constants and helpers for the BE-side FE queue buffer.
package bp_be_fe_queue_buffer_pkg;

  localparam int unsigned default_els_lp         = 8;
  localparam int unsigned default_entry_width_lp = 128;

  // clog2 that never returns 0, so a 1-deep index still gets one bit
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_be_fe_queue_buffer_if.sv
// Bundle of the FE enqueue channel, BE issue channel and commit/replay controls.
interface bp_be_fe_queue_buffer_if
  import bp_be_fe_queue_buffer_pkg::*;
#(
  parameter int unsigned entry_width_p = default_entry_width_lp
);

  logic [entry_width_p-1:0] fe_queue_i;
  logic                     fe_queue_v_i;
  logic                     fe_queue_ready_o;
  logic [entry_width_p-1:0] fe_queue_o;
  logic                     fe_queue_v_o;
  logic                     fe_queue_yumi_i;
  logic                     deq_v_i;
  logic                     roll_v_i;
  logic                     clr_v_i;
  logic                     empty_o;
  logic                     full_o;

  // buffer side
  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, deq_v_i, roll_v_i, clr_v_i,
    output fe_queue_ready_o, fe_queue_o, fe_queue_v_o, empty_o, full_o
  );

  // FE / BE issue side
  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, deq_v_i, roll_v_i, clr_v_i,
    input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o, empty_o, full_o
  );

endinterface

// File: rtl/bp_be_fe_queue_buffer_mem.sv
// 1-write/1-read storage array; read is combinational, write lands on the clock edge.
module bp_be_fe_queue_buffer_mem #(
  parameter int unsigned els_p        = 8,
  parameter int unsigned width_p      = 128,
  parameter int unsigned addr_width_p = 3
) (
  input  logic                    w_clk_i,
  input  logic                    w_v_i,
  input  logic [addr_width_p-1:0] w_addr_i,
  input  logic [width_p-1:0]      w_data_i,
  input  logic [addr_width_p-1:0] r_addr_i,
  output logic [width_p-1:0]      r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge w_clk_i) begin
    if (w_v_i) mem_q[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// BE receive buffer for FE queue entries with speculative issue, commit and replay.
module bp_be_fe_queue_buffer
  import bp_be_fe_queue_buffer_pkg::*;
#(
  parameter int unsigned els_p         = default_els_lp,
  parameter int unsigned entry_width_p = default_entry_width_lp
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bp_be_fe_queue_buffer_if.slave  q_if
);

  localparam int unsigned addr_width_lp = safe_clog2(els_p);
  localparam int unsigned ptr_width_lp  = addr_width_lp + 1;

  typedef logic [ptr_width_lp-1:0] ptr_t;

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t cptr_q, cptr_d;
  ptr_t occupancy;
  ptr_t cptr_adv;
  logic full;
  logic enq_v;
  logic wr_v;

  assign occupancy = wptr_q - cptr_q;
  assign full      = (occupancy == ptr_t'(els_p));

  assign q_if.full_o           = full;
  assign q_if.empty_o          = (wptr_q == cptr_q);
  assign q_if.fe_queue_ready_o = ~full;
  assign q_if.fe_queue_v_o     = (rptr_q != wptr_q);

  assign enq_v = q_if.fe_queue_v_i & ~full;
  // A flush drops any same-cycle enqueue: FE is redirected by the same event.
  assign wr_v  = enq_v & ~q_if.clr_v_i;

  // Next-pointer selection: clear beats roll beats independent enq/issue/commit.
  always_comb begin
    wptr_d   = wptr_q + ptr_t'(wr_v);
    cptr_adv = cptr_q + ptr_t'(q_if.deq_v_i);
    rptr_d   = rptr_q + ptr_t'(q_if.fe_queue_yumi_i);
    cptr_d   = cptr_adv;
    if (q_if.clr_v_i) begin
      rptr_d = wptr_q;
      cptr_d = wptr_q;
    end else if (q_if.roll_v_i) begin
      rptr_d = cptr_adv;
    end
  end

  // Pointer registers, asynchronously cleared.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  bp_be_fe_queue_buffer_mem #(
    .els_p        (els_p),
    .width_p      (entry_width_p),
    .addr_width_p (addr_width_lp)
  ) u_mem (
    .w_clk_i  (clk_i),
    .w_v_i    (wr_v),
    .w_addr_i (wptr_q[addr_width_lp-1:0]),
    .w_data_i (q_if.fe_queue_i),
    .r_addr_i (rptr_q[addr_width_lp-1:0]),
    .r_data_o (q_if.fe_queue_o)
  );

  // Protocol checks on the issue and commit side.
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (q_if.fe_queue_yumi_i && !q_if.clr_v_i && !q_if.roll_v_i) |-> q_if.fe_queue_v_o);
  a_deq_needs_issued: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (q_if.deq_v_i && !q_if.clr_v_i) |-> (cptr_q != rptr_q));

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Directed plus randomized bench for bp_be_fe_queue_buffer against a queue model.
module tb_bp_be_fe_queue_buffer;

  localparam int unsigned W   = 128;
  localparam int unsigned ELS = 8;

  logic clk = 1'b0;
  logic reset_n;

  bp_be_fe_queue_buffer_if #(.entry_width_p(W)) q_if ();

  bp_be_fe_queue_buffer #(
    .els_p         (ELS),
    .entry_width_p (W)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .q_if      (q_if)
  );

  always #5 clk = ~clk;

  // Model: entries held oldest-first; first iss of them have been issued.
  logic [W-1:0] held[$];
  int unsigned  iss;
  int unsigned  n_pass;
  int unsigned  n_total;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total += 1;
    assert (obs === exp) n_pass += 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic exp_v;
    exp_v = (iss < held.size());
    chk("empty", W'(q_if.empty_o), W'(held.size() == 0));
    chk("full", W'(q_if.full_o), W'(held.size() == ELS));
    chk("ready", W'(q_if.fe_queue_ready_o), W'(held.size() != ELS));
    chk("v_o", W'(q_if.fe_queue_v_o), W'(exp_v));
    if (exp_v) chk("data", q_if.fe_queue_o, held[iss]);
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d,
                            input logic y, input logic dq, input logic rl, input logic cl);
    logic enq;
    enq = v && (held.size() < ELS);
    if (cl) begin
      held.delete();
      iss = 0;
    end else if (rl) begin
      if (dq) void'(held.pop_front());
      iss = 0;
      if (enq) held.push_back(d);
    end else begin
      if (dq) begin
        void'(held.pop_front());
        iss = iss - 1;
      end
      if (y) iss = iss + 1;
      if (enq) held.push_back(d);
    end
  endtask

  task automatic idle_inputs();
    q_if.fe_queue_i      = '0;
    q_if.fe_queue_v_i    = 1'b0;
    q_if.fe_queue_yumi_i = 1'b0;
    q_if.deq_v_i         = 1'b0;
    q_if.roll_v_i        = 1'b0;
    q_if.clr_v_i         = 1'b0;
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d,
                       input logic y, input logic dq, input logic rl, input logic cl);
    q_if.fe_queue_v_i    = v;
    q_if.fe_queue_i      = d;
    q_if.fe_queue_yumi_i = y;
    q_if.deq_v_i         = dq;
    q_if.roll_v_i        = rl;
    q_if.clr_v_i         = cl;
    @(posedge clk);
    model_step(v, d, y, dq, rl, cl);
    #1;
    idle_inputs();
    check_all();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    iss     = 0;
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    check_all();
    chk("reset_ready", W'(q_if.fe_queue_ready_o), W'(1'b1));

    // Fill to capacity with no issue.
    for (int unsigned i = 1; i <= ELS; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fill_full", W'(q_if.full_o), W'(1'b1));
    chk("fill_head", q_if.fe_queue_o, W'(1));
    // Enqueue attempt while full plus a commit-free cycle: nothing taken.
    cycle(1'b1, W'(32'hDEAD), 1'b0, 1'b0, 1'b0, 1'b0);
    // Full with deq and enqueue together: enqueue refused, slot free next cycle.
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(32'hBEEF), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("freed_ready", W'(q_if.fe_queue_ready_o), W'(1'b1));
    cycle(1'b1, W'(32'hBEEF), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Issue/commit stream.
    cycle(1'b1, W'(32'hA), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(32'hB), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stream_a", q_if.fe_queue_o, W'(32'hA));
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stream_b", q_if.fe_queue_o, W'(32'hB));
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stream_empty", W'(q_if.empty_o), W'(1'b1));

    // Rollback after a partial commit.
    for (int unsigned i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("roll_head", q_if.fe_queue_o, W'(2));
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Roll together with a commit.
    cycle(1'b1, W'(1), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(2), 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rolldeq_head", q_if.fe_queue_o, W'(2));

    // Clear while holding 3 entries, with an enqueue the same cycle.
    cycle(1'b1, W'(7), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(8), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(32'h55), 1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_empty", W'(q_if.empty_o), W'(1'b1));
    chk("clr_v", W'(q_if.fe_queue_v_o), W'(1'b0));
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Twenty rounds through the slots to cross the wrap boundary.
    for (int unsigned r = 0; r < 20; r++) begin
      cycle(1'b1, W'(32'h100 + r), 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Randomized legal traffic.
    for (int unsigned k = 0; k < 400; k++) begin
      logic v, y, dq, rl, cl;
      logic [W-1:0] d;
      d  = {$urandom, $urandom, $urandom, $urandom};
      v  = ($urandom_range(0, 3) != 0);
      y  = (iss < held.size()) && ($urandom_range(0, 2) != 0);
      dq = (iss > 0) && ($urandom_range(0, 2) == 0);
      rl = ($urandom_range(0, 29) == 0);
      cl = ($urandom_range(0, 59) == 0);
      cycle(v, d, y, dq, rl, cl);
    end

    // Asynchronous reset while full, between clock edges.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int unsigned i = 0; i < ELS; i++) cycle(1'b1, W'(32'h200 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_full", W'(q_if.full_o), W'(1'b1));
    #1;
    reset_n = 1'b0;
    held.delete();
    iss = 0;
    #1;
    check_all();
    #2;
    reset_n = 1'b1;
    repeat (3) cycle(1'b1, W'(32'h300), 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
